// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// (IF) and a memory-stage data requester (DM).
//
// Ports
//   clk, reset            single clock, asynchronous active-low reset
//   if_req/if_addr        fetch read request, held until if_ack or if_kill
//   if_kill               squash the outstanding fetch (it still finishes on
//                         the memory port, just without if_ack)
//   if_ack/if_rdata       fetch completion and read data
//   dm_req/dm_we/dm_addr/dm_wdata   data request, held until dm_ack
//   dm_ack/dm_rdata       data completion and load data
//   mem_req/mem_we/mem_addr/mem_wdata   shared port command
//   mem_rdata/mem_ready   shared port response
//   stall_f/stall_m       pipeline stall requests
//   err                   sticky flag: a transaction waited TIMEOUT cycles
module mem_arbiter #(
   parameter int WORD       = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [WORD-1:0] if_addr,
   input  logic            if_kill,
   output logic            if_ack,
   output logic [WORD-1:0] if_rdata,
   input  logic            dm_req,
   input  logic            dm_we,
   input  logic [WORD-1:0] dm_addr,
   input  logic [WORD-1:0] dm_wdata,
   output logic            dm_ack,
   output logic [WORD-1:0] dm_rdata,
   output logic            mem_req,
   output logic            mem_we,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic [WORD-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic            stall_f,
   output logic            stall_m,
   output logic            err
);

   localparam int SW = $clog2(STARVE_MAX) + 1;
   localparam int BW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BUSY_LIM   = BW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      DM_BUSY = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [WORD-1:0] addr_q, addr_d;
   logic [WORD-1:0] wdata_q, wdata_d;
   logic            we_q, we_d;
   logic            kill_q, kill_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [BW-1:0]   busy_q, busy_d;
   logic            err_q, err_d;
   logic            kill_now;

   // A kill raised in the same cycle as mem_ready must already suppress if_ack.
   assign kill_now = kill_q | ((state_q == IF_BUSY) & if_kill);

   assign mem_req   = (state_q != IDLE);
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign if_ack    = (state_q == IF_BUSY) & mem_ready & ~kill_now;
   assign dm_ack    = (state_q == DM_BUSY) & mem_ready;
   assign if_rdata  = mem_rdata;
   assign dm_rdata  = mem_rdata;
   assign stall_f   = if_req & ~if_ack;
   assign stall_m   = dm_req & ~dm_ack;
   assign err       = err_q;

   // Next-state logic: arbitration in IDLE, completion/timeout tracking while busy.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      starve_d = starve_q;
      busy_d   = busy_q;
      err_d    = err_q;
      // The flag only lives while the killed fetch is still waiting.
      kill_d   = (state_q == IF_BUSY) & ~mem_ready & kill_now;
      case (state_q)
         IDLE: begin
            // DM wins unless IF has already been passed over STARVE_MAX times.
            if (dm_req && !(if_req && (starve_q == STARVE_LIM))) begin
               state_d = DM_BUSY;
               addr_d  = dm_addr;
               we_d    = dm_we;
               wdata_d = dm_wdata;
               busy_d  = '0;
               if (!if_req) begin
                  starve_d = '0;
               end else if (starve_q != STARVE_LIM) begin
                  starve_d = starve_q + 1'b1;
               end else begin
                  starve_d = starve_q;
               end
            end else if (if_req) begin
               state_d  = IF_BUSY;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               busy_d   = '0;
               starve_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         IF_BUSY, DM_BUSY: begin
            if (mem_ready) begin
               state_d = IDLE;
            end else begin
               if (busy_q != BUSY_LIM) begin
                  busy_d = busy_q + 1'b1;
               end else begin
                  busy_d = busy_q;
               end
               // Flag the timeout but keep waiting for the memory.
               err_d = err_q | (busy_d == BUSY_LIM);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and command registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         kill_q   <= 1'b0;
         starve_q <= '0;
         busy_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         kill_q   <= kill_d;
         starve_q <= starve_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORD, default 32, data and address width.
REQ-002 Parameter: STARVE_MAX, default 4, consecutive data grants allowed while fetch waits.
REQ-003 Parameter: TIMEOUT, default 255, busy cycles without mem_ready before error.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch read request; held with if_addr stable until if_ack or if_kill.
REQ-007 if_addr  in  WORD  fetch address.
REQ-008 if_kill  in  1  squash the outstanding fetch (branch taken).
REQ-009 if_ack  out  1  fetch complete; if_rdata valid this cycle.
REQ-010 if_rdata  out  WORD  fetch read data.
REQ-011 dm_req  in  1  memory-stage request; held with operands stable until dm_ack.
REQ-012 dm_we  in  1  1 = store, 0 = load.
REQ-013 dm_addr  in  WORD  data address.
REQ-014 dm_wdata  in  WORD  store data.
REQ-015 dm_ack  out  1  data access complete; dm_rdata valid this cycle.
REQ-016 dm_rdata  out  WORD  load data.
REQ-017 mem_req  out  1  shared memory port request.
REQ-018 mem_we, mem_addr, mem_wdata  out  1/WORD/WORD  shared port command.
REQ-019 mem_rdata  in  WORD; mem_ready  in  1  access done this cycle.
REQ-020 stall_f  out  1 and stall_m  out  1  pipeline stall requests.
REQ-021 err  out  1  sticky timeout flag.

Function
REQ-022 The FSM SHALL have states IDLE, IF_BUSY and DM_BUSY.
REQ-023 In IDLE, arbitration SHALL grant DM when dm_req=1, unless the starvation counter equals STARVE_MAX and if_req=1; in that case, and when only if_req=1, it SHALL grant IF. With no request it SHALL stay in IDLE.
REQ-024 At the granting edge, the block SHALL register the winner's addr, we and wdata (IF: we=0, wdata=0) into mem_addr, mem_we and mem_wdata, and enter the BUSY state.
REQ-025 mem_req SHALL be 1 exactly while the state is IF_BUSY or DM_BUSY; command outputs SHALL stay stable while busy.
REQ-026 if_ack SHALL equal (IF_BUSY & mem_ready & ~kill_flag), combinationally.
REQ-027 dm_ack SHALL equal (DM_BUSY & mem_ready), combinationally.
REQ-028 if_rdata and dm_rdata SHALL pass mem_rdata through.
REQ-029 On mem_ready in a BUSY state, the next state SHALL be IDLE. Throughput is one access per 2 cycles; minimum latency is 1 cycle from request to ack.
REQ-030 kill_flag SHALL set when if_kill=1 in IF_BUSY, clear on leaving IF_BUSY, and be treated as set in the if_kill cycle itself.
REQ-031 A killed fetch SHALL complete on the memory port (no abort) with no if_ack.
REQ-032 if_kill in IDLE or DM_BUSY SHALL have no effect.
REQ-033 Starvation counter (width log2(STARVE_MAX)+1):
  - increments on a DM grant while if_req=1;
  - clears on any IF grant;
  - clears on a DM grant while if_req=0;
  - saturates at STARVE_MAX.
REQ-034 stall_f SHALL equal if_req & ~if_ack; stall_m SHALL equal dm_req & ~dm_ack.
REQ-035 Busy counter:
  - clears on entering a BUSY state;
  - increments each BUSY cycle without mem_ready;
  - on reaching TIMEOUT, sets err=1 (sticky until reset) while the transaction keeps waiting;
  - saturates at TIMEOUT.
REQ-036 Simultaneous if_req and dm_req at reset release SHALL grant DM first.

Reset
REQ-037 When reset=0, asynchronously:
  - state SHALL be IDLE;
  - mem_req, mem_we, mem_addr, mem_wdata SHALL be 0;
  - if_ack, dm_ack SHALL be 0;
  - err, kill_flag, starvation counter and busy counter SHALL be 0.
REQ-038 Reset during a BUSY state SHALL drop mem_req immediately and abandon the transaction without an ack.

Verification
REQ-039 if_req=1, if_addr=0x100, mem_ready=1 the following cycle -> mem_req=1 and mem_addr=0x100 in cycle 1; if_ack=1 in cycle 1; state IDLE in cycle 2.
REQ-040 if_req and dm_req both held (store 0xDEADBEEF to 0x40), mem_ready always 1 -> DM is granted first with mem_we=1 and mem_wdata=0xDEADBEEF; stall_f=1 until IF is served.
REQ-041 if_req held, dm_req re-asserted after every dm_ack, mem_ready always 1 -> after 4 DM grants the 5th grant goes to IF; the counter then returns to 0.
REQ-042 IF_BUSY, if_kill=1 for one cycle, mem_ready after 3 cycles -> no if_ack; mem_req holds for those 3 cycles; then IDLE.
REQ-043 DM_BUSY with mem_ready held 0 for 300 cycles -> err=1 from busy cycle 255 on; dm_ack=1 when mem_ready rises; err stays 1.
REQ-044 reset=0 asserted mid DM_BUSY -> mem_req=0 immediately with no clock edge; no dm_ack; err=0.
